// File: rtl/upload_packer.sv
// Upload packer: gathers a handler's upload byte burst into a payload buffer and
// streams it to CDC TX as AA 44 src len_hi len_lo payload checksum.
module upload_packer #(
    parameter int unsigned MAX_PAYLOAD = 64,
    parameter logic [7:0]  HDR0        = 8'hAA,
    parameter logic [7:0]  HDR1        = 8'h44
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       upload_active,
    input  logic       upload_req,
    input  logic [7:0] upload_data,
    input  logic [7:0] upload_source,
    input  logic       upload_valid,
    output logic       upload_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam int unsigned PTR_W = $clog2(MAX_PAYLOAD) + 1;
    localparam int unsigned IDX_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] MAX_CNT = PTR_W'(MAX_PAYLOAD);

    typedef enum logic [3:0] {
        S_IDLE,
        S_COLLECT,
        S_HDR0,
        S_HDR1,
        S_SRC,
        S_LENH,
        S_LENL,
        S_DATA,
        S_CSUM
    } state_t;

    state_t           state_q;
    logic [PTR_W-1:0] count_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [7:0]       src_q;
    logic [7:0]       csum_q;
    logic [7:0]       out_data_q;
    logic             out_valid_q;
    logic             ready_q;
    logic [7:0]       buf_q [MAX_PAYLOAD];

    logic             strobe;
    logic             src_mismatch;
    logic             take;
    logic             collect_flush;
    logic             out_fire;
    logic             last_data;
    logic [PTR_W-1:0] count_inc;
    logic [PTR_W-1:0] len_next;
    logic [PTR_W-1:0] rd_next;
    logic [15:0]      flush_len;
    logic [15:0]      len16;
    logic [7:0]       take_byte;

    // A byte from a different source must not be taken into the current packet,
    // so the registered ready is masked by the live source comparison.
    assign strobe       = upload_req | upload_valid;
    assign src_mismatch = (state_q == S_COLLECT) && strobe && (upload_source != src_q);
    assign upload_ready = ready_q && !src_mismatch;
    assign take         = strobe && upload_ready;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign busy         = (state_q != S_IDLE);

    always_comb begin
        count_inc     = count_q + 1'b1;
        len_next      = take ? count_inc : count_q;
        flush_len     = 16'(len_next);
        len16         = 16'(count_q);
        take_byte     = take ? upload_data : 8'h00;
        rd_next       = rd_ptr_q + 1'b1;
        last_data     = (rd_ptr_q == count_q - 1'b1);
        out_fire      = out_valid_q && out_ready;
        collect_flush = (state_q == S_COLLECT) &&
                        (src_mismatch || !upload_active || (take && count_inc == MAX_CNT));
    end

    // Payload storage holds data only and is never reset; count_q bounds what is read.
    always_ff @(posedge clk) begin
        if (take) begin
            buf_q[count_q[IDX_W-1:0]] <= upload_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            src_q       <= 8'h00;
            csum_q      <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (take) begin
                        src_q   <= upload_source;
                        count_q <= {{(PTR_W-1){1'b0}}, 1'b1};
                        csum_q  <= upload_data;
                        state_q <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (take) begin
                        count_q <= count_inc;
                    end
                    // Source and length join the running sum once the length is final.
                    if (collect_flush) begin
                        csum_q      <= csum_q + take_byte + src_q + flush_len[15:8] + flush_len[7:0];
                        ready_q     <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= HDR0;
                        state_q     <= S_HDR0;
                    end else begin
                        csum_q  <= csum_q + take_byte;
                        ready_q <= 1'b1;
                    end
                end
                S_HDR0: begin
                    if (out_fire) begin
                        out_data_q <= HDR1;
                        state_q    <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (out_fire) begin
                        out_data_q <= src_q;
                        state_q    <= S_SRC;
                    end
                end
                S_SRC: begin
                    if (out_fire) begin
                        out_data_q <= len16[15:8];
                        state_q    <= S_LENH;
                    end
                end
                S_LENH: begin
                    if (out_fire) begin
                        out_data_q <= len16[7:0];
                        state_q    <= S_LENL;
                    end
                end
                S_LENL: begin
                    if (out_fire) begin
                        rd_ptr_q   <= '0;
                        out_data_q <= buf_q[0];
                        state_q    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (out_fire) begin
                        if (last_data) begin
                            out_data_q <= csum_q;
                            state_q    <= S_CSUM;
                        end else begin
                            rd_ptr_q   <= rd_next;
                            out_data_q <= buf_q[rd_next[IDX_W-1:0]];
                        end
                    end
                end
                S_CSUM: begin
                    if (out_fire) begin
                        out_valid_q <= 1'b0;
                        out_data_q  <= 8'h00;
                        count_q     <= '0;
                        rd_ptr_q    <= '0;
                        csum_q      <= 8'h00;
                        ready_q     <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    ready_q     <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upload_packer.sv
// Bench for upload_packer: drives upload bursts and compares the framed output
// stream against packets built directly from the framing rules.
module tb_upload_packer;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       upload_active;
    logic       upload_req;
    logic [7:0] upload_data;
    logic [7:0] upload_source;
    logic       upload_valid;
    logic       upload_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int total = 0;
    int bad   = 0;

    upload_packer #(.MAX_PAYLOAD(64), .HDR0(8'hAA), .HDR1(8'h44)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .upload_active (upload_active),
        .upload_req    (upload_req),
        .upload_data   (upload_data),
        .upload_source (upload_source),
        .upload_valid  (upload_valid),
        .upload_ready  (upload_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Packet as the host sees it: header, source, 16-bit length, payload, mod-256 sum.
    function automatic bq_t make_pkt(input logic [7:0] src, input bq_t pl);
        bq_t p;
        int  len;
        int  sum;
        len = pl.size();
        sum = src + (len / 256) + (len % 256);
        p = {8'hAA, 8'h44, src, 8'(len / 256), 8'(len % 256)};
        foreach (pl[i]) begin
            p.push_back(pl[i]);
            sum += pl[i];
        end
        p.push_back(8'(sum % 256));
        return p;
    endfunction

    // A burst longer than the buffer becomes consecutive packets of at most 64 bytes.
    function automatic bq_t make_burst(input logic [7:0] src, input bq_t pl);
        bq_t all;
        bq_t chunk;
        all = {};
        chunk = {};
        foreach (pl[i]) begin
            chunk.push_back(pl[i]);
            if (chunk.size() == 64) begin
                all = {all, make_pkt(src, chunk)};
                chunk = {};
            end
        end
        if (chunk.size() > 0) all = {all, make_pkt(src, chunk)};
        return all;
    endfunction

    task automatic push(input bq_t srcs, input bq_t dats, input bit drop, input bit rnd, output bit to);
        to = 1'b0;
        upload_active = 1'b1;
        for (int i = 0; i < dats.size(); i++) begin
            int w;
            w = 0;
            @(negedge clk);
            upload_source = srcs[i];
            upload_data   = dats[i];
            if (rnd && $urandom_range(0, 1) == 1) begin
                upload_valid = 1'b1;
                upload_req   = 1'b0;
            end else begin
                upload_req   = 1'b1;
                upload_valid = 1'b0;
            end
            #1;
            while (upload_ready !== 1'b1 && w < 3000) begin
                @(negedge clk);
                #1;
                w++;
            end
            if (w >= 3000) to = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        upload_req   = 1'b0;
        upload_valid = 1'b0;
        if (drop) upload_active = 1'b0;
    endtask

    task automatic collect(input int n, input int mode, output bq_t got,
                           output int hold_err, output int rdy_err, output bit to);
        int   cyc;
        bit   stalled;
        logic [7:0] held;
        got = {};
        hold_err = 0;
        rdy_err  = 0;
        stalled  = 1'b0;
        held     = 8'h00;
        cyc      = 0;
        while (got.size() < n && cyc < 4000) begin
            @(negedge clk);
            if (stalled && (out_valid !== 1'b1 || out_data !== held)) hold_err++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
            if (out_valid === 1'b1 && upload_ready !== 1'b0) rdy_err++;
            if (out_valid === 1'b1 && out_ready) got.push_back(out_data);
            stalled = (out_valid === 1'b1) && !out_ready;
            held    = out_data;
        end
        to = (got.size() < n);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h want=00", out_data); end
        total++; if (upload_ready !== 1'b0) begin bad++; $display("FAIL rst_upload_ready got=%b want=0", upload_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (upload_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", upload_ready); end
    endtask

    task automatic test_single_burst;
        bq_t src, pl, exp, got;
        int  he, re;
        bit  to_p, to_c;
        src = {8'h36, 8'h36, 8'h36, 8'h36};
        pl  = {8'h12, 8'h34, 8'h56, 8'h78};
        exp = make_pkt(8'h36, pl);
        fork
            push(src, pl, 1'b1, 1'b0, to_p);
            collect(exp.size(), 0, got, he, re, to_c);
        join
        total++; if (to_p || to_c) begin bad++; $display("FAIL single_timeout got=%0b%0b want=00", to_p, to_c); end
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL single_len got=%0d want=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL single_byte[%0d] got=%h want=%h", i, got[i], exp[i]); end
        end
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_back_pressure;
        bq_t src, pl, exp, got;
        int  he, re;
        bit  to_p, to_c;
        src = {8'h36, 8'h36, 8'h36, 8'h36};
        pl  = {8'h12, 8'h34, 8'h56, 8'h78};
        exp = make_pkt(8'h36, pl);
        fork
            push(src, pl, 1'b1, 1'b0, to_p);
            collect(exp.size(), 1, got, he, re, to_c);
        join
        total++; if (to_p || to_c) begin bad++; $display("FAIL bp_timeout got=%0b%0b want=00", to_p, to_c); end
        total++; if (he != 0) begin bad++; $display("FAIL bp_hold_stable got=%0d want=0", he); end
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL bp_len got=%0d want=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL bp_byte[%0d] got=%h want=%h", i, got[i], exp[i]); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overflow_split;
        bq_t src, pl, exp, got;
        int  he, re;
        bit  to_p, to_c;
        src = {};
        pl  = {};
        for (int i = 0; i < 70; i++) begin
            src.push_back(8'h35);
            pl.push_back(8'(i));
        end
        exp = make_burst(8'h35, pl);
        fork
            push(src, pl, 1'b1, 1'b0, to_p);
            collect(exp.size(), 0, got, he, re, to_c);
        join
        total++; if (to_p || to_c) begin bad++; $display("FAIL ovf_timeout got=%0b%0b want=00", to_p, to_c); end
        total++; if (re != 0) begin bad++; $display("FAIL ovf_ready_low_framing got=%0d want=0", re); end
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL ovf_len got=%0d want=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL ovf_byte[%0d] got=%h want=%h", i, got[i], exp[i]); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_source_change;
        bq_t src, pl, exp, got, p1, p2;
        int  he, re;
        bit  to_p, to_c;
        src = {8'h34, 8'h34, 8'h36};
        pl  = {8'hAA, 8'hBB, 8'h36};
        p1  = {8'hAA, 8'hBB};
        p2  = {8'h36};
        exp = {make_pkt(8'h34, p1), make_pkt(8'h36, p2)};
        fork
            push(src, pl, 1'b1, 1'b0, to_p);
            collect(exp.size(), 0, got, he, re, to_c);
        join
        total++; if (to_p || to_c) begin bad++; $display("FAIL srcchg_timeout got=%0b%0b want=00", to_p, to_c); end
        total++; if (re != 0) begin bad++; $display("FAIL srcchg_ready_low_framing got=%0d want=0", re); end
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL srcchg_len got=%0d want=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL srcchg_byte[%0d] got=%h want=%h", i, got[i], exp[i]); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_empty_burst;
        bit saw_valid, saw_busy;
        saw_valid = 1'b0;
        saw_busy  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        upload_active = 1'b1;
        upload_req    = 1'b0;
        upload_valid  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) upload_active = 1'b0;
            @(negedge clk);
            if (out_valid !== 1'b0) saw_valid = 1'b1;
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        total++; if (saw_valid) begin bad++; $display("FAIL empty_out_valid got=1 want=0"); end
        total++; if (saw_busy) begin bad++; $display("FAIL empty_busy got=1 want=0"); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 4; it++) begin
            bq_t src, pl, exp, got;
            int  he, re, len;
            bit  to_p, to_c;
            logic [7:0] s;
            s   = 8'($urandom_range(0, 255));
            len = $urandom_range(1, 100);
            src = {};
            pl  = {};
            for (int i = 0; i < len; i++) begin
                src.push_back(s);
                pl.push_back(8'($urandom_range(0, 255)));
            end
            exp = make_burst(s, pl);
            fork
                push(src, pl, 1'b1, 1'b1, to_p);
                collect(exp.size(), 2, got, he, re, to_c);
            join
            total++; if (to_p || to_c) begin bad++; $display("FAIL rand%0d_timeout got=%0b%0b want=00", it, to_p, to_c); end
            total++; if (he != 0 || re != 0) begin bad++; $display("FAIL rand%0d_hold_ready got=%0d/%0d want=0/0", it, he, re); end
            total++; if (got.size() != exp.size()) begin bad++; $display("FAIL rand%0d_len got=%0d want=%0d", it, got.size(), exp.size()); end
            for (int i = 0; i < exp.size() && i < got.size(); i++) begin
                total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL rand%0d_byte[%0d] got=%h want=%h", it, i, got[i], exp[i]); end
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_packet;
        bq_t src, pl;
        bit  to_p, saw_valid;
        int  seen, cyc;
        src = {};
        pl  = {};
        for (int i = 0; i < 20; i++) begin
            src.push_back(8'h51);
            pl.push_back(8'(8'h80 + i));
        end
        out_ready = 1'b0;
        push(src, pl, 1'b1, 1'b0, to_p);
        total++; if (to_p) begin bad++; $display("FAIL rstmid_push_timeout got=1 want=0"); end
        seen = 0;
        cyc  = 0;
        while (seen < 7 && cyc < 200) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (out_valid === 1'b1) seen++;
            cyc++;
        end
        total++; if (seen < 7) begin bad++; $display("FAIL rstmid_reach_data got=%0d want=7", seen); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
        total++; if (upload_ready !== 1'b0) begin bad++; $display("FAIL rstmid_upload_ready got=%b want=0", upload_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (upload_ready !== 1'b1) begin bad++; $display("FAIL rstmid_release_ready got=%b want=1", upload_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_release_busy got=%b want=0", busy); end
        saw_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0) saw_valid = 1'b1;
        end
        total++; if (saw_valid) begin bad++; $display("FAIL rstmid_discard got=1 want=0"); end
    endtask

    initial begin
        rst_n         = 1'b0;
        upload_active = 1'b0;
        upload_req    = 1'b0;
        upload_valid  = 1'b0;
        upload_data   = 8'h00;
        upload_source = 8'h00;
        out_ready     = 1'b0;
        test_reset;
        test_single_burst;
        test_back_pressure;
        test_overflow_split;
        test_source_change;
        test_empty_burst;
        test_random;
        test_reset_mid_packet;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
